// File: rtl/alu_pkg.sv
// Shared ALU command definitions: opcodes, field widths, queue entry layout
// and the issue FSM state encoding.
package alu_pkg;

    localparam int DATA_W  = 12;
    localparam int INST_W  = 3;
    localparam int ENTRY_W = 2 * DATA_W + INST_W;

    localparam logic [INST_W-1:0] OP_ADD    = 3'd0;
    localparam logic [INST_W-1:0] OP_SUB    = 3'd1;
    localparam logic [INST_W-1:0] OP_MUL    = 3'd2;
    localparam logic [INST_W-1:0] OP_MAC    = 3'd3;
    localparam logic [INST_W-1:0] OP_MIN    = 3'd4;
    localparam logic [INST_W-1:0] OP_MAX    = 3'd5;
    localparam logic [INST_W-1:0] OP_ABS    = 3'd6;
    localparam logic [INST_W-1:0] OP_ABSMAX = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [INST_W-1:0] inst;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command storage for alu_cmd_queue: DEPTH x 27-bit circular buffer with
// occupancy count; flush clears pointers and count and wins over push/pop.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  alu_cmd_t               i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output alu_cmd_t               o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int AW = $clog2(DEPTH);

    alu_cmd_t          mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = i_push && !o_full && !i_flush;
    assign do_pop  = i_pop && !o_empty && !i_flush;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else if (i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   o_count <= o_count + (AW+1)'(1);
                2'b01:   o_count <= o_count - (AW+1)'(1);
                default: o_count <= o_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_data;
    end

    assign o_head  = mem[rd_ptr];
    assign o_empty = (o_count == '0);
    assign o_full  = (o_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/alu_cmd_queue.sv
// ALU command queue: FIFO plus issue FSM with programmable post-issue gap.
// Optional ALU_CMD_STATS_EN adds a saturating 16-bit issue counter o_issue_cnt.
//
// state    | meaning
// ST_IDLE  | waiting for a queued command and no stall
// ST_ISSUE | popping head onto the output registers, o_valid next cycle
// ST_GAP   | counting down idle cycles loaded from i_gap
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [DATA_W-1:0]      i_in_a,
    input  logic [DATA_W-1:0]      i_in_b,
    input  logic [INST_W-1:0]      i_in_inst,
    input  logic                   i_flush,
    input  logic                   i_stall,
    input  logic [1:0]             i_gap,
    output logic                   o_valid,
    output logic [DATA_W-1:0]      o_data_a,
    output logic [DATA_W-1:0]      o_data_b,
    output logic [INST_W-1:0]      o_inst,
    output logic [$clog2(DEPTH):0] o_count,
`ifdef ALU_CMD_STATS_EN
    output logic [15:0]            o_issue_cnt,
`endif
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int CW = $clog2(DEPTH) + 1;

    issue_state_t state;
    logic [1:0]   gap_cnt;
    logic         in_rdy_en;
    logic         push;
    logic         pop;
    alu_cmd_t     in_cmd;
    alu_cmd_t     head;

    assign in_cmd     = '{a: i_in_a, b: i_in_b, inst: i_in_inst};
    assign o_in_ready = in_rdy_en && !o_full;
    assign push       = i_in_valid && o_in_ready && !i_flush;
    assign pop        = (state == ST_ISSUE) && !i_flush;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  (in_cmd),
        .i_pop   (pop),
        .i_flush (i_flush),
        .o_head  (head),
        .o_count (o_count),
        .o_empty (o_empty),
        .o_full  (o_full)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            in_rdy_en <= 1'b0;
            o_valid   <= 1'b0;
            o_data_a  <= '0;
            o_data_b  <= '0;
            o_inst    <= '0;
        end else begin
            in_rdy_en <= 1'b1;
            o_valid   <= 1'b0;
            if (i_flush) begin
                state   <= ST_IDLE;
                gap_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if ((o_count != '0) && !i_stall) state <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        o_valid  <= 1'b1;
                        o_data_a <= head.a;
                        o_data_b <= head.b;
                        o_inst   <= head.inst;
                        // Continuation looks at occupancy left after this pop.
                        if (i_gap != 2'd0) begin
                            state   <= ST_GAP;
                            gap_cnt <= i_gap;
                        end else if ((o_count > CW'(1)) && !i_stall) begin
                            state <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == 2'd1) begin
                            gap_cnt <= '0;
                            state   <= ((o_count != '0) && !i_stall) ? ST_ISSUE : ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - 2'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef ALU_CMD_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_issue_cnt <= '0;
        end else if (i_flush) begin
            o_issue_cnt <= '0;
        end else if (pop && (o_issue_cnt != 16'hFFFF)) begin
            o_issue_cnt <= o_issue_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue: directed scenarios plus a randomized run checked
// against a queue-based scoreboard and issue-timing rules.
module tb_alu_cmd_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_a;
    logic [11:0] in_b;
    logic [2:0]  in_inst;
    logic        flush;
    logic        stall;
    logic [1:0]  gap;
    logic        valid;
    logic [11:0] data_a;
    logic [11:0] data_b;
    logic [2:0]  inst;
    logic [3:0]  count;
    logic        empty;
    logic        full;
`ifdef ALU_CMD_STATS_EN
    logic [15:0] issue_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          c;
        logic [26:0] d;
    } iss_t;

    iss_t        issued [$];
    logic [26:0] exp_q  [$];
    logic [26:0] mq     [$];

    alu_cmd_queue dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_a     (in_a),
        .i_in_b     (in_b),
        .i_in_inst  (in_inst),
        .i_flush    (flush),
        .i_stall    (stall),
        .i_gap      (gap),
        .o_valid    (valid),
        .o_data_a   (data_a),
        .o_data_b   (data_b),
        .o_inst     (inst),
        .o_count    (count),
`ifdef ALU_CMD_STATS_EN
        .o_issue_cnt(issue_cnt),
`endif
        .o_empty    (empty),
        .o_full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && valid) issued.push_back('{cyc, {data_a, data_b, inst}});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [26:0] d);
        in_valid = 1'b1;
        {in_a, in_b, in_inst} = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_issued(input int n, input int budget);
        int k = 0;
        while (issued.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_issue", 32'(issued.size() >= n), 32'd1);
    endtask

    initial begin
        int          p;
        int          last_iss;
        int          last_gap;
        logic        sp1, sp2;
        logic        cur_stall, cur_flush, will_push, drain;
        logic [1:0]  cur_gap;
        logic [26:0] d, last_data, popped;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_inst = '0;
        flush = 1'b0; stall = 1'b0; gap = 2'd0;
        repeat (3) tick();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'({data_a, data_b, inst}), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(in_ready), 32'd0);
        tick();
        chk("ready_after_edge", 32'(in_ready), 32'd1);

        // Single command latency
        issued.delete();
        push_cmd({12'h040, 12'h020, 3'd0});
        p = cyc;
        wait_issued(1, 10);
        if (issued.size() > 0) begin
            chk("single_latency", 32'(issued[0].c - p), 32'd2);
            chk("single_data", 32'(issued[0].d), 32'({12'h040, 12'h020, 3'd0}));
        end
        chk("single_empty_after", 32'(empty), 32'd1);

        // Fill under stall, overflow attempt, then drain in order
        stall = 1'b1;
        tick();
        issued.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            d = 27'($urandom);
            chk("fill_ready", 32'(in_ready), 32'd1);
            exp_q.push_back(d);
            push_cmd(d);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready_low", 32'(in_ready), 32'd0);
        chk("fill_count", 32'(count), 32'd8);
        push_cmd(27'h5a5a5a5);
        chk("overflow_count", 32'(count), 32'd8);
        stall = 1'b0;
        wait_issued(8, 40);
        for (int i = 0; i < 8; i++) begin
            if (i < issued.size()) begin
                chk("fill_order", 32'(issued[i].d), 32'(exp_q[i]));
                chk("fill_b2b", 32'(issued[i].c - issued[0].c), 32'(i));
            end
        end
        repeat (2) tick();
        chk("fill_empty_after", 32'(empty), 32'd1);

        // Gap of two idle cycles between issues
        stall = 1'b1; gap = 2'd2;
        issued.delete();
        for (int i = 0; i < 3; i++) push_cmd(27'($urandom));
        stall = 1'b0;
        wait_issued(3, 40);
        if (issued.size() >= 3) begin
            chk("gap_second", 32'(issued[1].c - issued[0].c), 32'd3);
            chk("gap_third", 32'(issued[2].c - issued[0].c), 32'd6);
        end
        gap = 2'd0;
        repeat (4) tick();

        // MAC chain followed by ADD
        stall = 1'b1;
        issued.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            d = {12'($urandom), 12'($urandom), (i < 4) ? 3'd3 : 3'd0};
            exp_q.push_back(d);
            push_cmd(d);
        end
        stall = 1'b0;
        wait_issued(5, 30);
        for (int i = 0; i < 5; i++) begin
            if (i < issued.size()) begin
                chk("mac_order", 32'(issued[i].d), 32'(exp_q[i]));
                chk("mac_b2b", 32'(issued[i].c - issued[0].c), 32'(i));
            end
        end
        repeat (2) tick();

        // Flush with a same-cycle push while an issue is pending
        stall = 1'b1;
        for (int i = 0; i < 5; i++) push_cmd(27'($urandom));
        issued.delete();
        stall = 1'b0;
        tick();
        flush = 1'b1; in_valid = 1'b1; {in_a, in_b, in_inst} = 27'h1abcdef;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_no_valid", 32'(valid), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        repeat (6) tick();
        chk("flush_no_issue", 32'(issued.size()), 32'd0);
        chk("flush_count_later", 32'(count), 32'd0);

        // Reset asserted during a gap with entries still queued
        stall = 1'b1; gap = 2'd3;
        for (int i = 0; i < 4; i++) push_cmd(27'($urandom));
        issued.delete();
        stall = 1'b0;
        wait_issued(1, 10);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_data_a", 32'(data_a), 32'd0);
        chk("midrst_data_b", 32'(data_b), 32'd0);
        chk("midrst_inst", 32'(inst), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_full", 32'(full), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        gap = 2'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_ready_up", 32'(in_ready), 32'd1);
        repeat (10) tick();
        chk("midrst_no_issue", 32'(issued.size()), 32'd1);
        chk("midrst_count_after", 32'(count), 32'd0);

        // Randomized run against a queue scoreboard
        mq.delete();
        last_iss = -100; last_gap = 0; last_data = '0;
        sp1 = stall; sp2 = stall;
        for (int i = 0; i < 700; i++) begin
            drain = (i >= 620);
            chk("rnd_count", 32'(count), 32'(mq.size()));
            chk("rnd_ready", 32'(in_ready), 32'(mq.size() < 8));
            chk("rnd_empty", 32'(empty), 32'(mq.size() == 0));
            cur_stall = drain ? 1'b0 : ($urandom_range(0, 4) == 0);
            cur_gap   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            cur_flush = drain ? 1'b0 : ($urandom_range(0, 49) == 0);
            d         = 27'($urandom);
            in_valid  = drain ? 1'b0 : ($urandom_range(0, 9) < 6);
            {in_a, in_b, in_inst} = d;
            stall = cur_stall; gap = cur_gap; flush = cur_flush;
            will_push = in_valid && (mq.size() < 8) && !cur_flush;
            tick();
            sp2 = sp1; sp1 = cur_stall;
            if (cur_flush) begin
                chk("rnd_flush_valid", 32'(valid), 32'd0);
                chk("rnd_hold", 32'({data_a, data_b, inst}), 32'(last_data));
                mq.delete();
                last_iss = -100; last_gap = 0;
            end else begin
                if (valid) begin
                    chk("rnd_pop_nonempty", 32'(mq.size() > 0), 32'd1);
                    chk("rnd_gap_spacing", 32'(cyc >= last_iss + 1 + last_gap), 32'd1);
                    chk("rnd_stall_rule", 32'(sp2), 32'd0);
                    if (mq.size() > 0) begin
                        popped = mq.pop_front();
                        chk("rnd_data", 32'({data_a, data_b, inst}), 32'(popped));
                        last_data = popped;
                    end
                    last_iss = cyc; last_gap = int'(cur_gap);
                end else begin
                    chk("rnd_hold", 32'({data_a, data_b, inst}), 32'(last_data));
                end
                if (will_push) mq.push_back(d);
            end
        end
        in_valid = 1'b0; flush = 1'b0; stall = 1'b0; gap = 2'd0;
        chk("rnd_drained", 32'(mq.size()), 32'd0);
        chk("rnd_final_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
